// File: rtl/peri_interconnect.sv
// Peripheral bus decoder: routes one CPU access to one of NUM_SLOTS slaves, with wait states, timeout and error reply.
// Latency 2 cycles minimum (+1 per wait cycle); requests seen while busy are dropped, the master waits for ready.
module peri_interconnect #(
  parameter int NUM_SLOTS = 8,
  parameter int ADDR_W    = 14,
  parameter int FUNC_W    = 8,
  parameter int DEC_MSB   = 12,
  parameter int BASE_SLOT = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      address,
  input  logic [31:0]            write_data,
  input  logic                   we,
  input  logic                   re,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic                   err,
  output logic                   busy,
  output logic                   err_flag,
  output logic [ADDR_W-1:0]      err_addr,
  input  logic                   clr_err,
  output logic [FUNC_W-1:0]      s_addr,
  output logic [31:0]            s_wdata,
  output logic [NUM_SLOTS-1:0]   s_we,
  output logic [NUM_SLOTS-1:0]   s_re,
  input  logic [32*NUM_SLOTS-1:0] s_rdata,
  input  logic [NUM_SLOTS-1:0]   s_ready
);

  localparam int FIELD_W = DEC_MSB - FUNC_W + 1;
  localparam int SLOT_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t r_state, w_next;

  logic [FIELD_W-1:0]   w_field;
  logic                 w_req;
  logic                 w_mapped;
  logic [SLOT_W-1:0]    w_slot;
  logic [NUM_SLOTS-1:0] w_onehot;
  logic                 w_sel_ready;
  logic [31:0]          w_sel_rdata;
  logic                 w_is_write;
  logic [ADDR_W-1:0]    w_fail_addr;
  logic                 w_to_resp;
  logic                 w_resp_err;

  logic [SLOT_W-1:0]    r_slot;
  logic                 r_write;
  logic [ADDR_W-1:0]    r_addr;
  logic [CNT_W-1:0]     r_cnt;
  logic [FUNC_W-1:0]    r_s_addr;
  logic [31:0]          r_s_wdata;
  logic [NUM_SLOTS-1:0] r_s_we;
  logic [NUM_SLOTS-1:0] r_s_re;
  logic                 r_ready;
  logic                 r_err;
  logic [31:0]          r_rdata;
  logic                 r_err_flag;
  logic [ADDR_W-1:0]    r_err_addr;

  assign w_field     = address[DEC_MSB:FUNC_W];
  assign w_req       = re | we;
  assign w_mapped    = (int'(w_field) >= BASE_SLOT) && (int'(w_field) < BASE_SLOT + NUM_SLOTS);
  assign w_slot      = SLOT_W'(int'(w_field) - BASE_SLOT);
  assign w_onehot    = NUM_SLOTS'(1) << w_slot;
  assign w_sel_ready = s_ready[r_slot];
  assign w_sel_rdata = s_rdata[{r_slot, 5'd0} +: 32];
  // Unmapped accesses fail straight from IDLE, before anything is latched.
  assign w_is_write  = (r_state == IDLE) ? we : r_write;
  assign w_fail_addr = (r_state == IDLE) ? address : r_addr;

  always_comb begin
    w_next     = r_state;
    w_to_resp  = 1'b0;
    w_resp_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_mapped) begin
            w_next = ISSUE;
          end else begin
            w_next     = RESP;
            w_to_resp  = 1'b1;
            w_resp_err = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (w_sel_ready) begin
          w_next    = RESP;
          w_to_resp = 1'b1;
        end else begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (w_sel_ready) begin
          w_next    = RESP;
          w_to_resp = 1'b1;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
          w_next     = RESP;
          w_to_resp  = 1'b1;
          w_resp_err = 1'b1;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_slot     <= '0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_s_we     <= '0;
      r_s_re     <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_err_flag <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_state <= w_next;
      r_s_we  <= '0;
      r_s_re  <= '0;
      r_ready <= w_to_resp;
      r_err   <= w_resp_err;

      if ((r_state == IDLE) && w_req && w_mapped) begin
        r_slot    <= w_slot;
        r_write   <= we;
        r_addr    <= address;
        r_s_addr  <= address[FUNC_W-1:0];
        r_s_wdata <= write_data;
        if (we) r_s_we <= w_onehot;
        else    r_s_re <= w_onehot;
      end

      if (r_state == ISSUE)     r_cnt <= '0;
      else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;

      if (w_to_resp && !w_is_write) r_rdata <= w_resp_err ? 32'd0 : w_sel_rdata;

      // A new error outranks a clear arriving in the same cycle.
      if (w_to_resp && w_resp_err) begin
        r_err_flag <= 1'b1;
        r_err_addr <= w_fail_addr;
      end else if (clr_err) begin
        r_err_flag <= 1'b0;
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign read_data = r_rdata;
  assign ready     = r_ready;
  assign err       = r_err;
  assign err_flag  = r_err_flag;
  assign err_addr  = r_err_addr;
  assign s_addr    = r_s_addr;
  assign s_wdata   = r_s_wdata;
  assign s_we      = r_s_we;
  assign s_re      = r_s_re;

endmodule

// File: tb/tb_peri_interconnect.sv
// Scoreboard bench for peri_interconnect: expected responses are queued at issue, a monitor checks each ready pulse.
module tb_peri_interconnect;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [13:0]  address;
  logic [31:0]  write_data;
  logic         we, re;
  logic [31:0]  read_data;
  logic         ready, err, busy, err_flag;
  logic [13:0]  err_addr;
  logic         clr_err;
  logic [7:0]   s_addr;
  logic [31:0]  s_wdata;
  logic [7:0]   s_we, s_re;
  logic [255:0] s_rdata;
  logic [7:0]   s_ready;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  peri_interconnect #(
    .NUM_SLOTS(8), .ADDR_W(14), .FUNC_W(8), .DEC_MSB(12), .BASE_SLOT(1), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data),
    .we(we), .re(re), .read_data(read_data), .ready(ready), .err(err),
    .busy(busy), .err_flag(err_flag), .err_addr(err_addr), .clr_err(clr_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_re(s_re),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ready) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ready: got ready=1 read_data=%h err=%b, required no response", read_data, err);
      end else begin
        e = q.pop_front();
        if (read_data !== e.rdata || err !== e.err) begin
          n_fail++;
          $display("FAIL response: got read_data=%h err=%b, required read_data=%h err=%b",
                   read_data, err, e.rdata, e.err);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    exp_t x;
    x.rdata = d;
    x.err   = e;
    q.push_back(x);
  endtask

  // Drives a one-cycle request; returns in cycle 1 (one edge after sampling).
  task automatic issue(input logic [13:0] a, input logic r, input logic w, input logic [31:0] d);
    address    = a;
    re         = r;
    we         = w;
    write_data = d;
    step();
    re = 1'b0;
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; address = '0; write_data = '0; we = 1'b0; re = 1'b0;
    clr_err = 1'b0; s_rdata = '0; s_ready = '1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_err_flag", {31'd0, err_flag}, 32'd0);
    chk("rst_err_addr", {18'd0, err_addr}, 32'd0);
    chk("rst_strobes", {16'd0, s_we, s_re}, 32'd0);
    step();

    // Zero-wait read from slot 2
    s_rdata[64 +: 32] = 32'hDEADBEEF;
    push(32'hDEADBEEF, 1'b0);
    issue(14'h0310, 1'b1, 1'b0, 32'd0);
    chk("zw_s_re", {24'd0, s_re}, 32'h04);
    chk("zw_s_addr", {24'd0, s_addr}, 32'h10);
    chk("zw_busy", {31'd0, busy}, 32'd1);
    step();
    chk("zw_ready_c2", {31'd0, ready}, 32'd1);
    step(); step();

    // Wait-state write to slot 0, ready three cycles after strobe
    s_ready = 8'hFE;
    push(32'hDEADBEEF, 1'b0);
    issue(14'h0104, 1'b0, 1'b1, 32'h12345678);
    chk("ws_s_we_c1", {24'd0, s_we}, 32'h01);
    chk("ws_wdata_c1", s_wdata, 32'h12345678);
    step();
    chk("ws_s_we_c2", {24'd0, s_we}, 32'h00);
    chk("ws_wdata_c2", s_wdata, 32'h12345678);
    step();
    chk("ws_ready_c3", {31'd0, ready}, 32'd0);
    step();
    s_ready[0] = 1'b1;
    chk("ws_ready_c4", {31'd0, ready}, 32'd0);
    step();
    chk("ws_ready_c5", {31'd0, ready}, 32'd1);
    chk("ws_wdata_c5", s_wdata, 32'h12345678);
    s_ready = '1;
    step(); step();

    // Unmapped read
    push(32'd0, 1'b1);
    issue(14'h1F00, 1'b1, 1'b0, 32'd0);
    chk("um_strobes", {16'd0, s_we, s_re}, 32'd0);
    chk("um_ready_c1", {30'd0, ready, err}, 32'd3);
    chk("um_err_flag", {31'd0, err_flag}, 32'd1);
    chk("um_err_addr", {18'd0, err_addr}, 32'h1F00);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("um_clr_err_flag", {31'd0, err_flag}, 32'd0);
    step();

    // Busy: a read issued during WAIT is dropped
    s_ready = 8'hFE;
    s_rdata[0 +: 32] = 32'hA5A50001;
    push(32'hA5A50001, 1'b0);
    issue(14'h0104, 1'b1, 1'b0, 32'd0);
    chk("bz_s_re_c1", {24'd0, s_re}, 32'h01);
    step();
    issue(14'h0310, 1'b1, 1'b0, 32'd0);
    chk("bz_no_strobe", {16'd0, s_we, s_re}, 32'd0);
    chk("bz_s_addr_held", {24'd0, s_addr}, 32'h04);
    chk("bz_busy", {31'd0, busy}, 32'd1);
    s_ready[0] = 1'b1;
    step();
    chk("bz_ready_c4", {31'd0, ready}, 32'd1);
    s_ready = '1;
    step(); step();

    // Collision: re and we together act as a write
    push(32'hA5A50001, 1'b0);
    issue(14'h0310, 1'b1, 1'b1, 32'hCAFEF00D);
    chk("col_s_we", {24'd0, s_we}, 32'h04);
    chk("col_s_re", {24'd0, s_re}, 32'h00);
    chk("col_wdata", s_wdata, 32'hCAFEF00D);
    step(); step(); step();

    // Reset in the middle of WAIT
    s_ready = 8'hFD;
    issue(14'h0200, 1'b1, 1'b0, 32'd0);
    step(); step();
    chk("rw_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_busy", {31'd0, busy}, 32'd0);
    chk("rw_strobes", {16'd0, s_we, s_re}, 32'd0);
    chk("rw_read_data", read_data, 32'd0);
    step(); step();
    rst_n = 1'b1;
    repeat (8) step();
    chk("rw_idle_after", {31'd0, busy}, 32'd0);
    s_ready = '1;

    // Fresh read so the timeout has a nonzero read_data to clear
    push(32'hDEADBEEF, 1'b0);
    issue(14'h0310, 1'b1, 1'b0, 32'd0);
    step(); step(); step();

    // Timeout on slot 1 with TIMEOUT = 4
    s_ready = 8'hFD;
    push(32'd0, 1'b1);
    issue(14'h0200, 1'b1, 1'b0, 32'd0);
    chk("to_s_re", {24'd0, s_re}, 32'h02);
    for (int c = 2; c <= 5; c++) begin
      step();
      chk($sformatf("to_no_ready_c%0d", c), {31'd0, ready}, 32'd0);
    end
    step();
    chk("to_ready_c6", {30'd0, ready, err}, 32'd3);
    chk("to_err_flag", {31'd0, err_flag}, 32'd1);
    chk("to_err_addr", {18'd0, err_addr}, 32'h0200);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("to_clr_err_flag", {31'd0, err_flag}, 32'd0);
    s_ready = '1;
    repeat (3) step();

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
